// File: rtl/axi4_pkg.sv
// Shared AXI4 read-channel encodings, widths and the responder FSM state type.
package axi4_pkg;

    localparam int ALEN   = 8;
    localparam int ASIZE  = 3;
    localparam int ABURST = 2;
    localparam int RESP_W = 2;

    localparam logic [ABURST-1:0] BURST_FIXED = 2'd0;
    localparam logic [ABURST-1:0] BURST_INCR  = 2'd1;
    localparam logic [ABURST-1:0] BURST_WRAP  = 2'd2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'd0;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'd2;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;

endpackage

// File: rtl/axi4_rd_addr_gen.sv
// Per-beat address stepping, array range check and response classification.
module axi4_rd_addr_gen
    import axi4_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_WORDS = 4096,
    parameter int          IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic [31:0]       addr,
    input  logic [ASIZE-1:0]  size,
    input  logic [ABURST-1:0] burst,
    output logic [31:0]       next_addr,
    output logic [RESP_W-1:0] resp,
    output logic [IDX_W-1:0]  word_idx
);

    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

    logic [31:0] offset;
    logic        in_range;
    logic        illegal;

    assign offset    = addr - BASE_ADDR;
    assign in_range  = {1'b0, offset} < SPAN;
    assign word_idx  = offset[IDX_W+1:2];
    // An illegal request outranks a range miss: the whole burst reports SLVERR.
    assign illegal   = (size > 3'd2) || (burst > BURST_INCR);
    assign next_addr = (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;

    always_comb begin
        resp = RESP_OKAY;
        if (illegal)       resp = RESP_SLVERR;
        else if (!in_range) resp = RESP_DECERR;
    end

endmodule

// File: rtl/axi4_rd_sram_slave.sv
// AXI4 read responder over a word-addressed array, one outstanding burst at a time.
// Define AXI4_RD_SRAM_RAND_DELAY_EN for LFSR-driven extra latency and inter-beat bubbles.
module axi4_rd_sram_slave
    import axi4_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ID_WIDTH     = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          MEM_WORDS    = 4096,
    parameter int          READ_LATENCY = 2,
    parameter              INIT_FILE    = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           araddr,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ALEN-1:0]       arlen,
    input  logic [ASIZE-1:0]      arsize,
    input  logic [ABURST-1:0]     arburst,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [RESP_W-1:0]     rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic                  rlast
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = 5;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_t              state, state_nxt;
    logic [31:0]         addr;
    logic [ID_WIDTH-1:0] id_q;
    logic [ALEN-1:0]     len_q, beat_cnt;
    logic [ASIZE-1:0]    size_q;
    logic [ABURST-1:0]   burst_q;
    logic [CNT_W-1:0]    lat_cnt, lat_tgt, extra;
    logic [31:0]         next_addr;
    logic [RESP_W-1:0]   beat_resp;
    logic [IDX_W-1:0]    word_idx;
    logic                ar_hs, r_hs, wait_done, gap_load, bubble, load;

    // addr always holds the address of the next beat to be fetched.
    axi4_rd_addr_gen #(
        .BASE_ADDR (BASE_ADDR),
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_addr_gen (
        .addr      (addr),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr),
        .resp      (beat_resp),
        .word_idx  (word_idx)
    );

`ifdef AXI4_RD_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign extra    = {2'b00, lfsr[2:0]};
    assign bubble   = lfsr[0];
    assign gap_load = (state == BEAT) && !rvalid;
`else
    assign extra    = '0;
    assign bubble   = 1'b0;
    assign gap_load = 1'b0;
`endif

    assign arready   = (state == IDLE);
    assign ar_hs     = arvalid && arready;
    assign r_hs      = rvalid && rready;
    assign wait_done = (state == WAIT) && (lat_cnt == lat_tgt);
    assign load      = wait_done || gap_load || (r_hs && !rlast && !bubble);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (ar_hs) state_nxt = WAIT;
            WAIT:    if (wait_done) state_nxt = BEAT;
            BEAT:    if (r_hs && rlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr     <= '0;
            id_q     <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            lat_cnt  <= '0;
            lat_tgt  <= '0;
            beat_cnt <= '0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rresp    <= '0;
            rid      <= '0;
            rdata    <= '0;
        end else begin
            if (ar_hs) begin
                addr     <= araddr;
                id_q     <= arid;
                len_q    <= arlen;
                size_q   <= arsize;
                burst_q  <= arburst;
                lat_cnt  <= '0;
                lat_tgt  <= CNT_W'(READ_LATENCY - 1) + extra;
                beat_cnt <= '0;
            end
            if ((state == WAIT) && !wait_done) lat_cnt <= lat_cnt + 1'b1;
            if (load) begin
                rvalid   <= 1'b1;
                rdata    <= (beat_resp == RESP_OKAY) ? mem[word_idx] : '0;
                rresp    <= beat_resp;
                rid      <= id_q;
                rlast    <= (beat_cnt == len_q);
                beat_cnt <= beat_cnt + 1'b1;
                addr     <= next_addr;
            end else if (r_hs) begin
                rvalid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_rd_sram_slave.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_axi4_rd_sram_slave;

    localparam int          DW   = 32;
    localparam int          IW   = 4;
    localparam int          MW   = 4096;
    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   araddr = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IW-1:0] arid = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b1;
    logic [IW-1:0] rid;
    logic          rlast;

    always #5 clk = ~clk;

    axi4_rd_sram_slave #(
        .DATA_WIDTH   (DW),
        .ID_WIDTH     (IW),
        .BASE_ADDR    (BASE),
        .MEM_WORDS    (MW),
        .READ_LATENCY (LAT),
        .INIT_FILE    ("")
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .arid    (arid),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .rid     (rid),
        .rlast   (rlast)
    );

    typedef struct {
        logic [31:0]   data;
        logic [1:0]    resp;
        logic [IW-1:0] id;
        logic          last;
    } beat_t;

    beat_t       exp_q[$];
    int          hs_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          pop_cnt = 0;
    bit          abort = 0;
    bit          rr_rand = 0;
    bit          stall_first = 0;
    logic [31:0] ref_mem [MW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: beats derived straight from the burst/response rules.
    task automatic push_exp(input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu, input logic [IW-1:0] id);
        logic [31:0] cur, off;
        beat_t b;
        cur = a;
        for (int i = 0; i <= int'(len); i++) begin
            off    = cur - BASE;
            b.id   = id;
            b.last = (i == int'(len));
            if (sz > 3'd2 || bu >= 2'd2) begin
                b.resp = 2'd2; b.data = '0;
            end else if (off >= 32'(4 * MW)) begin
                b.resp = 2'd3; b.data = '0;
            end else begin
                b.resp = 2'd0; b.data = ref_mem[off[13:2]];
            end
            exp_q.push_back(b);
            if (bu == 2'd1) cur = cur + (32'd1 << sz);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [IW-1:0] id, input bit wait_done);
        int g;
        int tgt;
        if (abort) return;
        tgt = done_cnt + 1;
        push_exp(a, len, sz, bu, id);
        @(negedge clk);
        g = 0;
        while (!arready && g < 300) begin @(negedge clk); g++; end
        if (!arready) begin
            tests++; fails++; abort = 1;
            $display("FAIL ar_accept_timeout: got arready=0 required 1 within 300 cycles");
            return;
        end
        araddr = a; arlen = len; arsize = sz; arburst = bu; arid = id; arvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
        hs_q.push_back(cyc);
        @(negedge clk);
        chk("arready_drop", arready, 0);
        if (wait_done) begin
            g = 0;
            while (done_cnt < tgt && g < 600) begin @(posedge clk); g++; end
            if (done_cnt < tgt) begin
                tests++; fails++; abort = 1;
                $display("FAIL burst_timeout: got %0d bursts done required %0d", done_cnt, tgt);
                return;
            end
            @(negedge clk);
            chk("arready_after_last", arready, 1);
        end
    endtask

    // rready driver: optional 3-cycle stall on the first visible beat, else random or high.
    initial begin
        int hold_low;
        hold_low = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_first && rvalid) begin stall_first = 0; hold_low = 3; end
            if (hold_low > 0) begin rready = 1'b0; hold_low--; end
            else rready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: beat compare, stall stability, first-beat latency.
    initial begin
        bit    stalled;
        logic  prev_rv;
        beat_t held, e;
        stalled = 0;
        prev_rv = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 0; prev_rv = 0;
            end else begin
                if (stalled)
                    chk("stall_hold", {24'd0, rvalid, rlast, rresp, rid, rdata},
                        {24'd0, 1'b1, held.last, held.resp, held.id, held.data});
`ifndef AXI4_RD_SRAM_RAND_DELAY_EN
                if (rvalid && !prev_rv && hs_q.size() > 0)
                    chk("first_latency", 64'(cyc), 64'(hs_q.pop_front() + LAT));
`endif
                if (rvalid && rready) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_beat: got rdata=%h rid=%h with none required", rdata, rid);
                    end else begin
                        e = exp_q.pop_front();
                        chk("r_beat", {25'd0, rlast, rresp, rid, rdata}, {25'd0, e.last, e.resp, e.id, e.data});
                        pop_cnt++;
                        if (e.last) done_cnt++;
                    end
                    stalled = 0;
                end else if (rvalid) begin
                    stalled   = 1;
                    held.data = rdata; held.resp = rresp; held.id = rid; held.last = rlast;
                end else begin
                    stalled = 0;
                end
                prev_rv = rvalid;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  sz;
        logic [1:0]  bu;
        int          g, p0;

        for (int i = 0; i < MW; i++) begin
            ref_mem[i] = $urandom;
            if (i == 4) ref_mem[i] = 32'hDEAD_BEEF;
            dut.mem[i] = ref_mem[i];
        end

        @(negedge clk);
        chk("reset_arready", arready, 1);
        chk("reset_rvalid", rvalid, 0);
        chk("reset_rlast", rlast, 0);
        chk("reset_rresp", rresp, 0);
        chk("reset_rid", rid, 0);
        chk("reset_rdata", rdata, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        do_read(32'h8000_0010, 8'd0, 3'd2, 2'd1, 4'd3, 1);
        do_read(32'h8000_0000, 8'd3, 3'd2, 2'd1, 4'd1, 1);
        stall_first = 1;
        do_read(32'h8000_0000, 8'd3, 3'd2, 2'd1, 4'd6, 1);
        do_read(32'h8000_4000, 8'd1, 3'd2, 2'd1, 4'd2, 1);
        do_read(32'h8000_0020, 8'd2, 3'd3, 2'd1, 4'd7, 1);
        do_read(32'h8000_0020, 8'd2, 3'd2, 2'd2, 4'd8, 1);
        do_read(32'h8000_0030, 8'd2, 3'd2, 2'd0, 4'd9, 1);
        do_read(32'h8000_3FF8, 8'd3, 3'd2, 2'd1, 4'd10, 1);

        // Reset during the second beat of a four-beat burst.
        p0 = pop_cnt;
        do_read(32'h8000_0040, 8'd3, 3'd2, 2'd1, 4'd5, 0);
        g = 0;
        while (pop_cnt < p0 + 1 && g < 100) begin @(posedge clk); g++; end
        if (!abort) begin
            #3 reset = 1'b1;
            #1;
            chk("midreset_rvalid", rvalid, 0);
            chk("midreset_arready", arready, 1);
            exp_q.delete();
            hs_q.delete();
            @(posedge clk);
            #1 reset = 1'b0;
        end
        do_read(32'h8000_0010, 8'd1, 3'd2, 2'd1, 4'd11, 1);

        rr_rand = 1;
        for (int t = 0; t < 40; t++) begin
            g   = $urandom_range(0, 9);
            a   = BASE + (32'($urandom_range(0, MW - 1)) << 2) + 32'($urandom_range(0, 3));
            if (g == 0) a = BASE + 32'(4 * MW) - 32'd8;
            if (g == 1) a = BASE - 32'd4;
            len = 8'($urandom_range(0, 7));
            sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            bu  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3))
                                              : (($urandom_range(0, 3) == 0) ? 2'd0 : 2'd1);
            do_read(a, len, sz, bu, 4'($urandom_range(0, 15)), 1);
        end

        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
